// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Reads are combinational; writes, issues and flushes take effect on the rising edge.
module regfile_mp #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic                  flush,
    output logic [AW:0]           busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Issue is applied after writeback so a new producer wins over a retiring one.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (wr_en && (wr_addr != '0)) begin
                busy_next[wr_addr] = 1'b0;
            end
            if (iss_en && (iss_addr != '0)) begin
                busy_next[iss_addr] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= popcount(busy_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Bypass is gated by rst_n so outputs read zero for as long as reset is held.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (rd_addr[i*AW +: AW] != '0) begin
                if ((BYPASS != 0) && wr_en && rst_n && (wr_addr == rd_addr[i*AW +: AW])) begin
                    rd_data[i*XLEN +: XLEN] = wr_data;
                    rd_busy[i]              = 1'b0;
                end else begin
                    rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
                    rd_busy[i]              = busy[rd_addr[i*AW +: AW]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass and non-bypass 2-port instances plus a
// 4-port 32-bit instance, driven from a vector table and a few hand sequences.
module tb_regfile_mp;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam logic [63:0] Z    = 64'd0;
    localparam logic [63:0] DB   = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] K42  = 64'd42;
    localparam logic [63:0] K99  = 64'd99;
    localparam logic [63:0] K123 = 64'h123;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        b0;
        logic        b1;
        logic [63:0] nd0;
        logic        nb0;
        logic [5:0]  cnt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [9:0]   rd_addr;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         iss_en;
    logic [4:0]   iss_addr;
    logic         flush;
    logic [127:0] a_rd_data;
    logic [1:0]   a_rd_busy;
    logic [5:0]   a_cnt;
    logic [127:0] b_rd_data;
    logic [1:0]   b_rd_busy;
    logic [5:0]   b_cnt;
    logic [19:0]  c_rd_addr;
    logic [127:0] c_rd_data;
    logic [3:0]   c_rd_busy;
    logic [31:0]  c_wr_data;
    logic [5:0]   c_cnt;

    int checks = 0;
    int errors = 0;
    vec_t vecs[16];

    assign c_wr_data = wr_data[31:0];

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(64), .NREGS(32), .NREAD(2), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(a_cnt)
    );

    regfile_mp #(.XLEN(64), .NREGS(32), .NREAD(2), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(b_cnt)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(4), .BYPASS(1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .rd_busy(c_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(c_wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(c_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{Y, 5'd5,  DB,   N, 5'd0,  N, 5'd5,  5'd5,  DB,   DB,   N, N, Z,    N, 6'd0};
        vecs[1]  = '{N, 5'd0,  Z,    N, 5'd0,  N, 5'd5,  5'd0,  DB,   Z,    N, N, DB,   N, 6'd0};
        vecs[2]  = '{Y, 5'd0,  ONES, Y, 5'd0,  N, 5'd0,  5'd0,  Z,    Z,    N, N, Z,    N, 6'd0};
        vecs[3]  = '{N, 5'd0,  Z,    Y, 5'd7,  N, 5'd7,  5'd9,  Z,    Z,    N, N, Z,    N, 6'd1};
        vecs[4]  = '{N, 5'd0,  Z,    Y, 5'd9,  N, 5'd7,  5'd9,  Z,    Z,    Y, N, Z,    Y, 6'd2};
        vecs[5]  = '{Y, 5'd7,  K42,  N, 5'd0,  N, 5'd7,  5'd9,  K42,  Z,    N, Y, Z,    Y, 6'd1};
        vecs[6]  = '{Y, 5'd9,  K99,  Y, 5'd9,  N, 5'd7,  5'd9,  K42,  K99,  N, N, K42,  N, 6'd1};
        vecs[7]  = '{N, 5'd0,  Z,    N, 5'd0,  N, 5'd9,  5'd7,  K99,  K42,  Y, N, K99,  Y, 6'd1};
        vecs[8]  = '{N, 5'd0,  Z,    Y, 5'd3,  N, 5'd3,  5'd9,  Z,    K99,  N, Y, Z,    N, 6'd2};
        vecs[9]  = '{N, 5'd0,  Z,    Y, 5'd4,  N, 5'd3,  5'd4,  Z,    Z,    Y, N, Z,    Y, 6'd3};
        vecs[10] = '{N, 5'd0,  Z,    Y, 5'd10, N, 5'd4,  5'd10, Z,    Z,    Y, N, Z,    Y, 6'd4};
        vecs[11] = '{N, 5'd0,  Z,    Y, 5'd11, Y, 5'd10, 5'd11, Z,    Z,    Y, N, Z,    Y, 6'd0};
        vecs[12] = '{N, 5'd0,  Z,    N, 5'd0,  N, 5'd11, 5'd9,  Z,    K99,  N, N, Z,    N, 6'd0};
        vecs[13] = '{Y, 5'd3,  K123, Y, 5'd3,  Y, 5'd3,  5'd3,  K123, K123, N, N, Z,    N, 6'd0};
        vecs[14] = '{N, 5'd0,  Z,    N, 5'd0,  N, 5'd3,  5'd5,  K123, DB,   N, N, K123, N, 6'd0};
        vecs[15] = '{N, 5'd0,  Z,    Y, 5'd12, N, 5'd5,  5'd5,  DB,   DB,   N, N, DB,   N, 6'd1};

        // Reset held: every register reads zero and not busy on both ports.
        rst_n     = 1'b0;
        idle();
        rd_addr   = '0;
        c_rd_addr = '0;
        #2;
        for (int r = 0; r < 32; r++) begin
            rd_addr = {5'(31 - r), 5'(r)};
            #1;
            chk($sformatf("rst_byp_r%0d", r), {a_rd_busy, 2'b00} | 64'(a_rd_data != '0), 64'd0);
            chk($sformatf("rst_nobyp_r%0d", r), {b_rd_busy, 2'b00} | 64'(b_rd_data != '0), 64'd0);
        end
        chk("rst_cnt_byp", 64'(a_cnt), 64'd0);
        chk("rst_cnt_nobyp", 64'(b_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            wr_en    = vecs[i].we;
            wr_addr  = vecs[i].wa;
            wr_data  = vecs[i].wd;
            iss_en   = vecs[i].ie;
            iss_addr = vecs[i].ia;
            flush    = vecs[i].fl;
            rd_addr  = {vecs[i].a1, vecs[i].a0};
            #1;
            chk($sformatf("v%0d_d0", i), a_rd_data[63:0], vecs[i].d0);
            chk($sformatf("v%0d_d1", i), a_rd_data[127:64], vecs[i].d1);
            chk($sformatf("v%0d_b0", i), 64'(a_rd_busy[0]), 64'(vecs[i].b0));
            chk($sformatf("v%0d_b1", i), 64'(a_rd_busy[1]), 64'(vecs[i].b1));
            chk($sformatf("v%0d_nd0", i), b_rd_data[63:0], vecs[i].nd0);
            chk($sformatf("v%0d_nb0", i), 64'(b_rd_busy[0]), 64'(vecs[i].nb0));
            tick();
            chk($sformatf("v%0d_cnt", i), 64'(a_cnt), 64'(vecs[i].cnt));
            chk($sformatf("v%0d_ncnt", i), 64'(b_cnt), 64'(vecs[i].cnt));
        end

        // x12 is busy and x5 holds data; an asynchronous reset pulse between edges clears both.
        idle();
        rd_addr = {5'd5, 5'd12};
        #1;
        chk("pre_rst_busy12", 64'(a_rd_busy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_d12", a_rd_data[63:0], Z);
        chk("async_rst_b12", 64'(a_rd_busy[0]), 64'd0);
        chk("async_rst_d5", a_rd_data[127:64], Z);
        chk("async_rst_cnt", 64'(a_cnt), 64'd0);
        chk("async_rst_ncnt", 64'(b_cnt), 64'd0);
        wr_en   = 1'b1;
        wr_addr = 5'd12;
        wr_data = ONES;
        #1;
        chk("rst_bypass_gated", a_rd_data[63:0], Z);
        idle();
        rst_n = 1'b1;
        #1;
        chk("post_rst_d12", a_rd_data[63:0], Z);
        chk("post_rst_b12", 64'(a_rd_busy[0]), 64'd0);

        // First write after reset release is taken on the next edge.
        wr_en   = 1'b1;
        wr_addr = 5'd6;
        wr_data = 64'd77;
        rd_addr = {5'd5, 5'd6};
        #1;
        chk("first_wr_nobyp_old", b_rd_data[63:0], Z);
        tick();
        idle();
        #1;
        chk("first_wr_nobyp_new", b_rd_data[63:0], 64'd77);

        // 4-port 32-bit instance: bypass visible on all ports in the write cycle.
        wr_en     = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 64'hFFFF_0000_0123_4567;
        c_rd_addr = {5'd5, 5'd5, 5'd5, 5'd5};
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("w4_byp_d%0d", p), 64'(c_rd_data[p*32 +: 32]), 64'h0123_4567);
            chk($sformatf("w4_byp_b%0d", p), 64'(c_rd_busy[p]), 64'd0);
        end
        tick();
        idle();
        c_rd_addr = {5'd5, 5'd0, 5'd6, 5'd5};
        #1;
        chk("w4_p0", 64'(c_rd_data[31:0]), 64'h0123_4567);
        chk("w4_p1", 64'(c_rd_data[63:32]), 64'd77);
        chk("w4_p2", 64'(c_rd_data[95:64]), 64'd0);
        chk("w4_p3", 64'(c_rd_data[127:96]), 64'h0123_4567);
        chk("w4_cnt", 64'(c_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
